// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: register index and the
// buffered long-latency write request.
package regfile_wb_arbiter_pkg;

    localparam int unsigned CoreXlen = 32;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t              rd;
        logic [CoreXlen-1:0]   data;
    } wb_req_t;

    function automatic logic [31:0] rd_onehot(input reg_idx_t rd);
        return 32'(1) << rd;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO of writeback requests; also reports whether any queued
// entry targets a given register.
module regfile_wb_arbiter_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_sync_i,
    input  logic     push_i,
    input  wb_req_t  wdata_i,
    input  logic     pop_i,
    output wb_req_t  rdata_o,
    output logic     full_o,
    output logic     empty_o,
    input  reg_idx_t probe_rd_i,
    output logic     probe_hit_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    wb_req_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW:0]      wptr_q, rptr_q;
    logic [AW-1:0]    widx, ridx;
    logic             do_push, do_pop;

    assign widx    = wptr_q[AW-1:0];
    assign ridx    = rptr_q[AW-1:0];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);
    assign rdata_o = mem_q[ridx];

    // A pop frees the head slot, so a push into a full FIFO is legal alongside it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        vld_d = vld_q;
        if (do_pop) begin
            vld_d[ridx] = 1'b0;
        end
        if (do_push) begin
            vld_d[widx] = 1'b1;
        end
    end

    always_comb begin
        probe_hit_o = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld_q[i] && (mem_q[i].rd == probe_rd_i)) begin
                probe_hit_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_sync_i) begin
        if (rst_sync_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            vld_q  <= '0;
        end else begin
            vld_q <= vld_d;
            if (do_push) begin
                wptr_q <= wptr_q + (AW + 1)'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[widx] <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered long-latency results, and tracks pending long-latency destinations.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN            = CoreXlen,  // must equal CoreXlen
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned STARVE_LIMIT    = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic            clk_i,
    input  logic            rst_sync_i,
    input  logic            pipe_wb_valid_i,
    input  reg_idx_t        pipe_wb_rd_i,
    input  logic [XLEN-1:0] pipe_wb_data_i,
    output logic            pipe_hold_o,
    input  logic            lat_valid_i,
    output logic            lat_ready_o,
    input  reg_idx_t        lat_rd_i,
    input  logic [XLEN-1:0] lat_data_i,
    input  logic            iss_valid_i,
    input  logic            iss_long_i,
    input  reg_idx_t        iss_rs1_i,
    input  logic            iss_rs1_used_i,
    input  reg_idx_t        iss_rs2_i,
    input  logic            iss_rs2_used_i,
    input  reg_idx_t        iss_rd_i,
    output logic            iss_stall_o,
    output reg_idx_t        reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic            reg_wen_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t       head, lat_req;
    logic          fifo_full, fifo_empty, fifo_hit;
    logic          lat_push, fifo_grant, pipe_grant;
    logic          sb_set, sb_clr;
    logic [31:0]   pending_q, pending_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          steal_q, steal_d;

    assign lat_req     = '{rd: lat_rd_i, data: lat_data_i};
    assign lat_ready_o = !fifo_full;
    assign lat_push    = lat_valid_i && !fifo_full;

    regfile_wb_arbiter_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_sync_i  (rst_sync_i),
        .push_i      (lat_push),
        .wdata_i     (lat_req),
        .pop_i       (fifo_grant),
        .rdata_o     (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .probe_rd_i  (pipe_wb_rd_i),
        .probe_hit_o (fifo_hit)
    );

    // In a steal cycle the pipeline request is ignored; it re-presents next cycle.
    assign fifo_grant  = !fifo_empty && (steal_q || !pipe_wb_valid_i);
    assign pipe_grant  = pipe_wb_valid_i && !steal_q;
    assign pipe_hold_o = steal_q;

    always_comb begin
        reg_wen_o   = 1'b0;
        reg_waddr_o = '0;
        reg_wdata_o = '0;
        if (!rst_sync_i) begin
            if (fifo_grant) begin
                reg_wen_o   = (head.rd != '0);
                reg_waddr_o = head.rd;
                reg_wdata_o = head.data;
            end else if (pipe_grant) begin
                reg_wen_o   = (pipe_wb_rd_i != '0);
                reg_waddr_o = pipe_wb_rd_i;
                reg_wdata_o = pipe_wb_data_i;
            end
        end
    end

    always_comb begin
        iss_stall_o = 1'b0;
        if (!rst_sync_i && iss_valid_i) begin
            iss_stall_o = (iss_rs1_used_i && pending_q[iss_rs1_i]) ||
                          (iss_rs2_used_i && pending_q[iss_rs2_i]) ||
                          pending_q[iss_rd_i] ||
                          (iss_long_i && (cnt_q == CW'(MAX_OUTSTANDING)));
        end
    end

    assign sb_set = iss_valid_i && iss_long_i && !iss_stall_o && (iss_rd_i != '0);
    assign sb_clr = fifo_grant && (head.rd != '0);

    // Clear before set so a same-cycle set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (sb_clr) begin
            pending_d = pending_d & ~rd_onehot(head.rd);
        end
        if (sb_set) begin
            pending_d = pending_d | rd_onehot(iss_rd_i);
        end
        pending_d[0] = 1'b0;

        unique case ({sb_set, sb_clr})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        starve_d = starve_q;
        if (fifo_grant) begin
            starve_d = '0;
        end else if (pipe_grant && !fifo_empty) begin
            starve_d = starve_q + SW'(1);
        end
        steal_d = (starve_d == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk_i or posedge rst_sync_i) begin
        if (rst_sync_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            steal_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            steal_q   <= steal_d;
        end
    end

    a_pipe_rd_not_queued: assert property (@(posedge clk_i) disable iff (rst_sync_i)
        (pipe_wb_valid_i && (pipe_wb_rd_i != '0)) |-> !fifo_hit);
    a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (rst_sync_i)
        !(sb_clr && !sb_set && (cnt_q == '0)));
    a_lat_rd_pending: assert property (@(posedge clk_i) disable iff (rst_sync_i)
        (lat_valid_i && (lat_rd_i != '0)) |-> pending_q[lat_rd_i]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: write-port arbitration, slot stealing,
// FIFO back-pressure, x0 handling, scoreboard stalls and asynchronous reset.
module tb_regfile_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_sync_i;
    logic        pipe_wb_valid_i;
    logic [4:0]  pipe_wb_rd_i;
    logic [31:0] pipe_wb_data_i;
    logic        pipe_hold_o;
    logic        lat_valid_i;
    logic        lat_ready_o;
    logic [4:0]  lat_rd_i;
    logic [31:0] lat_data_i;
    logic        iss_valid_i;
    logic        iss_long_i;
    logic [4:0]  iss_rs1_i;
    logic        iss_rs1_used_i;
    logic [4:0]  iss_rs2_i;
    logic        iss_rs2_used_i;
    logic [4:0]  iss_rd_i;
    logic        iss_stall_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_wen_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter u_dut (
        .clk_i           (clk_i),
        .rst_sync_i      (rst_sync_i),
        .pipe_wb_valid_i (pipe_wb_valid_i),
        .pipe_wb_rd_i    (pipe_wb_rd_i),
        .pipe_wb_data_i  (pipe_wb_data_i),
        .pipe_hold_o     (pipe_hold_o),
        .lat_valid_i     (lat_valid_i),
        .lat_ready_o     (lat_ready_o),
        .lat_rd_i        (lat_rd_i),
        .lat_data_i      (lat_data_i),
        .iss_valid_i     (iss_valid_i),
        .iss_long_i      (iss_long_i),
        .iss_rs1_i       (iss_rs1_i),
        .iss_rs1_used_i  (iss_rs1_used_i),
        .iss_rs2_i       (iss_rs2_i),
        .iss_rs2_used_i  (iss_rs2_used_i),
        .iss_rd_i        (iss_rd_i),
        .iss_stall_o     (iss_stall_o),
        .reg_waddr_o     (reg_waddr_o),
        .reg_wdata_o     (reg_wdata_o),
        .reg_wen_o       (reg_wen_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        pipe_wb_valid_i = 1'b0; pipe_wb_rd_i = '0; pipe_wb_data_i = '0;
        lat_valid_i = 1'b0; lat_rd_i = '0; lat_data_i = '0;
        iss_valid_i = 1'b0; iss_long_i = 1'b0; iss_rd_i = '0;
        iss_rs1_i = '0; iss_rs1_used_i = 1'b0; iss_rs2_i = '0; iss_rs2_used_i = 1'b0;
    endtask

    // Advance one cycle; inputs go idle just after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
        clear_inputs();
    endtask

    task automatic set_pipe(input logic [4:0] rd, input logic [31:0] data);
        pipe_wb_valid_i = 1'b1; pipe_wb_rd_i = rd; pipe_wb_data_i = data;
    endtask

    task automatic set_lat(input logic [4:0] rd, input logic [31:0] data);
        lat_valid_i = 1'b1; lat_rd_i = rd; lat_data_i = data;
    endtask

    task automatic set_iss(input logic lng, input logic [4:0] rs1, input logic rs1u,
                           input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd);
        iss_valid_i = 1'b1; iss_long_i = lng; iss_rd_i = rd;
        iss_rs1_i = rs1; iss_rs1_used_i = rs1u; iss_rs2_i = rs2; iss_rs2_used_i = rs2u;
    endtask

    task automatic check_write(input string tag, input logic wen, input logic [4:0] addr,
                               input logic [31:0] data);
        check_eq({tag, "_wen"}, 64'(reg_wen_o), 64'(wen));
        check_eq({tag, "_waddr"}, 64'(reg_waddr_o), 64'(addr));
        check_eq({tag, "_wdata"}, 64'(reg_wdata_o), 64'(data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sync_i = 1'b1;
        clear_inputs();
        #2;
        check_write("rst", 1'b0, 5'd0, 32'h0);
        check_eq("rst_hold", 64'(pipe_hold_o), 64'd0);
        check_eq("rst_stall", 64'(iss_stall_o), 64'd0);
        check_eq("rst_lat_ready", 64'(lat_ready_o), 64'd1);

        // Pipeline write alone goes straight through.
        cyc(); rst_sync_i = 1'b0;
        set_pipe(5'd5, 32'h11); #1;
        check_write("t1", 1'b1, 5'd5, 32'h11);
        check_eq("t1_hold", 64'(pipe_hold_o), 64'd0);

        // RAW stall on a long-latency destination until its result is written.
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7); #1;
        check_eq("t2_issue_stall", 64'(iss_stall_o), 64'd0);
        cyc(); set_iss(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8); set_lat(5'd7, 32'hAB); #1;
        check_eq("t2_raw_stall", 64'(iss_stall_o), 64'd1);
        check_eq("t2_lat_ready", 64'(lat_ready_o), 64'd1);
        check_eq("t2_no_write", 64'(reg_wen_o), 64'd0);
        cyc(); set_iss(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8); #1;
        check_write("t2_lat", 1'b1, 5'd7, 32'hAB);
        check_eq("t2_stall_during_wr", 64'(iss_stall_o), 64'd1);
        cyc(); set_iss(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8); #1;
        check_eq("t2_stall_drop", 64'(iss_stall_o), 64'd0);

        // Starvation: four pipe grants with a queued result, then one stolen slot.
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9); #1;
        check_eq("t3_issue_stall", 64'(iss_stall_o), 64'd0);
        cyc(); set_lat(5'd9, 32'h99); set_pipe(5'd10, 32'h100); #1;
        check_write("t3_accept", 1'b1, 5'd10, 32'h100);
        for (int i = 1; i <= 4; i++) begin
            cyc(); set_pipe(5'(10 + i), 32'(i)); #1;
            check_write($sformatf("t3_pipe%0d", i), 1'b1, 5'(10 + i), 32'(i));
            check_eq($sformatf("t3_hold%0d", i), 64'(pipe_hold_o), 64'd0);
        end
        cyc(); set_pipe(5'd15, 32'h5); #1;
        check_eq("t3_steal_hold", 64'(pipe_hold_o), 64'd1);
        check_write("t3_steal", 1'b1, 5'd9, 32'h99);
        cyc(); set_pipe(5'd15, 32'h5); #1;
        check_eq("t3_resume_hold", 64'(pipe_hold_o), 64'd0);
        check_write("t3_resume", 1'b1, 5'd15, 32'h5);

        // FIFO back-pressure with the pipeline busy.
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12);
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13);
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14); #1;
        check_eq("t4_issue_stall", 64'(iss_stall_o), 64'd0);
        cyc(); set_pipe(5'd20, 32'h20); set_lat(5'd12, 32'hC); #1;
        check_eq("t4_ready_l1", 64'(lat_ready_o), 64'd1);
        cyc(); set_pipe(5'd20, 32'h20); set_lat(5'd13, 32'hD); #1;
        check_eq("t4_ready_l2", 64'(lat_ready_o), 64'd1);
        for (int i = 3; i <= 5; i++) begin
            cyc(); set_pipe(5'd20, 32'h20); set_lat(5'd14, 32'hE); #1;
            check_eq($sformatf("t4_full_l%0d", i), 64'(lat_ready_o), 64'd0);
            check_write($sformatf("t4_pipe_l%0d", i), 1'b1, 5'd20, 32'h20);
        end
        cyc(); set_pipe(5'd20, 32'h20); set_lat(5'd14, 32'hE); #1;
        check_eq("t4_steal_hold", 64'(pipe_hold_o), 64'd1);
        check_eq("t4_steal_ready", 64'(lat_ready_o), 64'd0);
        check_write("t4_steal", 1'b1, 5'd12, 32'hC);
        cyc(); set_lat(5'd14, 32'hE); #1;
        check_eq("t4_enq_deq_ready", 64'(lat_ready_o), 64'd1);
        check_write("t4_pop13", 1'b1, 5'd13, 32'hD);
        cyc(); #1;
        check_write("t4_pop14", 1'b1, 5'd14, 32'hE);
        check_eq("t4_drain_ready", 64'(lat_ready_o), 64'd1);

        // x0: never pending, never written, but FIFO entries still pop.
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0); set_pipe(5'd0, 32'h77);
        set_lat(5'd0, 32'h55); #1;
        check_eq("t5_stall_long_x0", 64'(iss_stall_o), 64'd0);
        check_eq("t5_pipe_x0_wen", 64'(reg_wen_o), 64'd0);
        cyc(); set_iss(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0); set_pipe(5'd0, 32'h78);
        set_lat(5'd0, 32'h56); #1;
        check_eq("t5_stall_src_x0", 64'(iss_stall_o), 64'd0);
        check_eq("t5_ready_e2", 64'(lat_ready_o), 64'd1);
        cyc(); #1;
        check_eq("t5_full", 64'(lat_ready_o), 64'd0);
        check_eq("t5_fifo_x0_wen", 64'(reg_wen_o), 64'd0);
        cyc(); #1;
        check_eq("t5_popped_ready", 64'(lat_ready_o), 64'd1);

        // Asynchronous reset mid-stream with queued results and pending hazards.
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21);
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22);
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd23);
        cyc(); set_pipe(5'd2, 32'h2); set_lat(5'd21, 32'h21);
        cyc(); set_pipe(5'd2, 32'h2); set_lat(5'd22, 32'h22); #1;
        check_eq("t6_ready_pre", 64'(lat_ready_o), 64'd1);
        cyc(); set_pipe(5'd2, 32'h2); set_iss(1'b0, 5'd23, 1'b1, 5'd0, 1'b0, 5'd24); #1;
        check_eq("t6_full_pre", 64'(lat_ready_o), 64'd0);
        check_eq("t6_stall_pre", 64'(iss_stall_o), 64'd1);
        rst_sync_i = 1'b1; #1;
        check_write("t6_rst", 1'b0, 5'd0, 32'h0);
        check_eq("t6_rst_hold", 64'(pipe_hold_o), 64'd0);
        check_eq("t6_rst_stall", 64'(iss_stall_o), 64'd0);
        check_eq("t6_rst_ready", 64'(lat_ready_o), 64'd1);
        cyc(); rst_sync_i = 1'b0;
        set_iss(1'b0, 5'd21, 1'b1, 5'd22, 1'b1, 5'd23); #1;
        check_eq("t6_post_stall", 64'(iss_stall_o), 64'd0);
        check_eq("t6_post_wen", 64'(reg_wen_o), 64'd0);
        check_eq("t6_post_ready", 64'(lat_ready_o), 64'd1);
        cyc(); set_iss(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd23); #1;
        check_eq("t6_post_waw", 64'(iss_stall_o), 64'd0);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
